// File: rtl/pwm_cmd_loader.sv
// Byte-serial command loader for a PWM stage: an asynchronous 4-phase strobe
// bus writes shadow duty/period values that commit at the PWM period boundary.
module pwm_cmd_loader #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] bus_data,
  input  logic             bus_strobe,
  input  logic             period_end,
  output logic [WIDTH-1:0] duty,
  output logic [WIDTH-1:0] max_value,
  output logic             bus_ack,
  output logic             pending,
  output logic             err,
  output logic [1:0]       dbg_state
);

  localparam logic [1:0] S_IDLE          = 2'd0;
  localparam logic [1:0] S_DATA_DUTY     = 2'd1;
  localparam logic [1:0] S_DATA_MAX      = 2'd2;
  localparam logic [1:0] S_DATA_BOTH_MAX = 2'd3;

  localparam logic [WIDTH-1:0] OP_CLR_ERR = WIDTH'(0);
  localparam logic [WIDTH-1:0] OP_DUTY    = WIDTH'(1);
  localparam logic [WIDTH-1:0] OP_MAX     = WIDTH'(2);
  localparam logic [WIDTH-1:0] OP_BOTH    = WIDTH'(3);
  localparam logic [WIDTH-1:0] OP_COMMIT  = WIDTH'(4);

  logic             r_sync1, r_sync2, r_sync2_d;
  logic [1:0]       r_warm;
  logic             r_armed;
  logic             r_ack;
  logic [1:0]       r_state;
  logic             r_both;
  logic [WIDTH-1:0] r_shadow_duty, r_shadow_max;
  logic [WIDTH-1:0] r_duty, r_max;
  logic             r_pending, r_err;

  logic w_byte_valid;
  logic w_idle, w_wr_duty, w_wr_max, w_set_pending, w_commit;

  // Handshake: the host raises bus_strobe with bus_data stable; bus_ack rises
  // once the byte is taken, the host drops bus_strobe, and bus_ack then falls.
  // A byte needs two consecutive samples high (short glitches are dropped), and
  // the edge detector only arms once the synchronizer has seen the strobe low
  // after reset, so a strobe held across reset release is not taken as a byte.
  assign w_byte_valid = r_armed & r_sync1 & r_sync2 & ~r_sync2_d;

  assign w_idle        = (r_state == S_IDLE);
  assign w_wr_duty     = w_byte_valid & (r_state == S_DATA_DUTY);
  assign w_wr_max      = w_byte_valid & ((r_state == S_DATA_MAX) | (r_state == S_DATA_BOTH_MAX));
  assign w_set_pending = (w_wr_duty & ~r_both) | w_wr_max;
  assign w_commit      = (w_byte_valid & w_idle & (bus_data == OP_COMMIT)) | (period_end & r_pending);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_sync2_d <= 1'b0;
      r_warm    <= 2'b00;
      r_armed   <= 1'b0;
      r_ack     <= 1'b0;
    end else begin
      r_sync1   <= bus_strobe;
      r_sync2   <= r_sync1;
      r_sync2_d <= r_sync2;
      r_warm    <= {r_warm[0], 1'b1};
      r_armed   <= r_armed | (r_warm[1] & ~r_sync2);
      if (w_byte_valid) begin
        r_ack <= 1'b1;
      end else if (!r_sync2) begin
        r_ack <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_both  <= 1'b0;
      r_err   <= 1'b0;
    end else if (w_byte_valid) begin
      case (r_state)
        S_IDLE: begin
          r_both <= 1'b0;
          if (bus_data == OP_CLR_ERR) begin
            r_err <= 1'b0;
          end else if (bus_data == OP_DUTY) begin
            r_state <= S_DATA_DUTY;
          end else if (bus_data == OP_MAX) begin
            r_state <= S_DATA_MAX;
          end else if (bus_data == OP_BOTH) begin
            r_state <= S_DATA_DUTY;
            r_both  <= 1'b1;
          end else if (bus_data != OP_COMMIT) begin
            r_err <= 1'b1;
          end
        end
        S_DATA_DUTY: begin
          r_state <= r_both ? S_DATA_BOTH_MAX : S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_both  <= 1'b0;
        end
      endcase
    end
  end

  // Shadow writes and commits share an edge: the commit reads the pre-write
  // shadow values, and pending stays set so the new value lands next period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow_duty <= '0;
      r_shadow_max  <= '1;
      r_duty        <= '0;
      r_max         <= '1;
      r_pending     <= 1'b0;
    end else begin
      if (w_wr_duty) r_shadow_duty <= bus_data;
      if (w_wr_max)  r_shadow_max  <= bus_data;
      if (w_commit) begin
        r_duty <= (r_shadow_duty > r_shadow_max) ? r_shadow_max : r_shadow_duty;
        r_max  <= r_shadow_max;
      end
      if (w_set_pending) begin
        r_pending <= 1'b1;
      end else if (w_commit && !w_wr_duty && !w_wr_max) begin
        r_pending <= 1'b0;
      end
    end
  end

  assign duty      = r_duty;
  assign max_value = r_max;
  assign bus_ack   = r_ack;
  assign pending   = r_pending;
  assign err       = r_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_pwm_cmd_loader.sv
// Directed bench for pwm_cmd_loader: drives the strobe/ack bus and period_end,
// and checks outputs against hand-computed values with immediate assertions.
module tb_pwm_cmd_loader;

  logic       clk;
  logic       rst_n;
  logic [7:0] bus_data;
  logic       bus_strobe;
  logic       period_end;
  logic [7:0] duty;
  logic [7:0] max_value;
  logic       bus_ack;
  logic       pending;
  logic       err;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int ack_rises = 0;
  int ack_base;

  pwm_cmd_loader #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus_data   (bus_data),
    .bus_strobe (bus_strobe),
    .period_end (period_end),
    .duty       (duty),
    .max_value  (max_value),
    .bus_ack    (bus_ack),
    .pending    (pending),
    .err        (err),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge bus_ack) ack_rises++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // driver tasks
  task automatic send_byte(input logic [7:0] b);
    int t;
    @(negedge clk);
    bus_data   = b;
    bus_strobe = 1'b1;
    t = 0;
    while (bus_ack !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) check("ack_rise_timeout", 32'(bus_ack), 32'd1);
    bus_strobe = 1'b0;
    t = 0;
    while (bus_ack !== 1'b0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) check("ack_fall_timeout", 32'(bus_ack), 32'd0);
    idle(2);
  endtask

  // byte whose accepting edge coincides with a period_end pulse
  task automatic send_byte_with_pe(input logic [7:0] b);
    int t;
    @(negedge clk);
    bus_data   = b;
    bus_strobe = 1'b1;
    @(negedge clk);
    @(negedge clk);
    period_end = 1'b1;
    @(negedge clk);
    period_end = 1'b0;
    t = 0;
    while (bus_ack !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) check("pe_ack_rise_timeout", 32'(bus_ack), 32'd1);
    bus_strobe = 1'b0;
    t = 0;
    while (bus_ack !== 1'b0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) check("pe_ack_fall_timeout", 32'(bus_ack), 32'd0);
    idle(2);
  endtask

  task automatic pulse_pe();
    @(negedge clk);
    period_end = 1'b1;
    @(negedge clk);
    period_end = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    bus_data   = 8'h00;
    bus_strobe = 1'b0;
    period_end = 1'b0;
    #23;
    check("rst_duty",    32'(duty),      32'h00);
    check("rst_max",     32'(max_value), 32'hFF);
    check("rst_pending", 32'(pending),   32'd0);
    check("rst_err",     32'(err),       32'd0);
    check("rst_ack",     32'(bus_ack),   32'd0);
    check("rst_state",   32'(dbg_state), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(5);

    // duty load committed at period end
    send_byte(8'h01);
    check("duty_ptr_state",   32'(dbg_state), 32'd1);
    check("duty_ptr_pending", 32'(pending),   32'd0);
    send_byte(8'h40);
    check("duty_wr_pending", 32'(pending), 32'd1);
    check("duty_wr_no_out",  32'(duty),    32'h00);
    pulse_pe();
    check("pe_duty",    32'(duty),      32'h40);
    check("pe_max",     32'(max_value), 32'hFF);
    check("pe_pending", 32'(pending),   32'd0);

    // period_end with nothing pending
    pulse_pe();
    check("idle_pe_duty", 32'(duty),      32'h40);
    check("idle_pe_max",  32'(max_value), 32'hFF);

    // both-command, clamp and immediate commit
    send_byte(8'h03);
    send_byte(8'h90);
    check("both_mid_state",   32'(dbg_state), 32'd3);
    check("both_mid_pending", 32'(pending),   32'd0);
    send_byte(8'h80);
    check("both_pending", 32'(pending), 32'd1);
    check("both_no_out",  32'(duty),    32'h40);
    send_byte(8'h04);
    check("imm_duty_clamp", 32'(duty),      32'h80);
    check("imm_max",        32'(max_value), 32'h80);
    check("imm_pending",    32'(pending),   32'd0);

    // illegal opcode is sticky and non-blocking
    send_byte(8'hA5);
    check("illegal_err",   32'(err),       32'd1);
    check("illegal_duty",  32'(duty),      32'h80);
    check("illegal_max",   32'(max_value), 32'h80);
    check("illegal_state", 32'(dbg_state), 32'd0);
    send_byte(8'h01);
    send_byte(8'h20);
    check("err_nonblock_pending", 32'(pending), 32'd1);
    check("err_still_set",        32'(err),     32'd1);
    pulse_pe();
    check("err_nonblock_duty", 32'(duty), 32'h20);
    send_byte(8'h00);
    check("err_cleared", 32'(err), 32'd0);

    // shadow write coinciding with period_end
    send_byte(8'h02);
    send_byte(8'h60);
    check("max_wr_pending", 32'(pending), 32'd1);
    send_byte(8'h01);
    send_byte_with_pe(8'h30);
    check("coll_duty",    32'(duty),      32'h20);
    check("coll_max",     32'(max_value), 32'h60);
    check("coll_pending", 32'(pending),   32'd1);
    pulse_pe();
    check("coll_next_duty",    32'(duty),      32'h30);
    check("coll_next_max",     32'(max_value), 32'h60);
    check("coll_next_pending", 32'(pending),   32'd0);

    // reset mid-command, strobe held across reset release
    send_byte(8'h02);
    check("mid_cmd_state", 32'(dbg_state), 32'd2);
    @(negedge clk);
    bus_data   = 8'hA5;
    bus_strobe = 1'b1;
    rst_n      = 1'b0;
    #1;
    check("mid_rst_max",   32'(max_value), 32'hFF);
    check("mid_rst_duty",  32'(duty),      32'h00);
    check("mid_rst_state", 32'(dbg_state), 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(6);
    check("held_strobe_ack", 32'(bus_ack), 32'd0);
    check("held_strobe_err", 32'(err),     32'd0);
    bus_strobe = 1'b0;
    idle(4);
    send_byte(8'h10);
    check("post_rst_illegal_err", 32'(err),       32'd1);
    check("post_rst_state",       32'(dbg_state), 32'd0);
    check("post_rst_max",         32'(max_value), 32'hFF);

    // glitch filter: 1-clk strobe ignored, 4-clk strobe taken once
    ack_base = ack_rises;
    @(negedge clk);
    bus_data   = 8'h00;
    bus_strobe = 1'b1;
    @(negedge clk);
    bus_strobe = 1'b0;
    idle(6);
    check("short_ack_count", 32'(ack_rises - ack_base), 32'd0);
    check("short_err_kept",  32'(err),                  32'd1);
    bus_strobe = 1'b1;
    idle(4);
    bus_strobe = 1'b0;
    idle(8);
    check("long_ack_count", 32'(ack_rises - ack_base), 32'd1);
    check("long_ack_low",   32'(bus_ack),              32'd0);
    check("long_err_clr",   32'(err),                  32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
